// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: ALU-control op codes, FSM states, bus size codes.
// ST_DRAIN exists only when MEMACC_FLUSH_CANCEL_EN is defined.
package mem_access_unit_pkg;

   localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3
`ifdef MEMACC_FLUSH_CANCEL_EN
      ,
      ST_DRAIN = 3'd4
`endif
   } mau_state_e;

   // Sub-word stores place the datum on every lane so the bridge can use byte enables only.
   function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         SIZE_BYTE: return {4{wd[7:0]}};
         SIZE_HALF: return {2{wd[15:0]}};
         default:   return wd;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus between the memory access unit (master) and the data bus bridge (slave).
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
) ();
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_align_chk.sv
// Combinational op/address decoder: memory-op class, access size, AdEL/AdES and the bad address.
module mem_align_chk
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OP_W   = 8
) (
   input  logic              check_en,
   input  logic [OP_W-1:0]   op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] pc,
   output logic              is_mem,
   output logic              is_load,
   output logic              is_signed,
   output logic [1:0]        size,
   output logic              adel,
   output logic              ades,
   output logic [ADDR_W-1:0] bad_addr
);

   logic misaligned;

   always_comb begin
      is_mem    = 1'b1;
      is_load   = 1'b0;
      is_signed = 1'b0;
      size      = SIZE_BYTE;
      case (op)
         OP_W'(EXE_LB_OP):  begin is_load = 1'b1; is_signed = 1'b1; size = SIZE_BYTE; end
         OP_W'(EXE_LBU_OP): begin is_load = 1'b1; size = SIZE_BYTE; end
         OP_W'(EXE_LH_OP):  begin is_load = 1'b1; is_signed = 1'b1; size = SIZE_HALF; end
         OP_W'(EXE_LHU_OP): begin is_load = 1'b1; size = SIZE_HALF; end
         OP_W'(EXE_LW_OP):  begin is_load = 1'b1; size = SIZE_WORD; end
         OP_W'(EXE_SB_OP):  size = SIZE_BYTE;
         OP_W'(EXE_SH_OP):  size = SIZE_HALF;
         OP_W'(EXE_SW_OP):  size = SIZE_WORD;
         default:           is_mem = 1'b0;
      endcase
   end

   assign misaligned = ((size == SIZE_HALF) && addr[0]) ||
                       ((size == SIZE_WORD) && (addr[1:0] != 2'b00));

   assign adel     = check_en && is_mem && is_load && misaligned;
   assign ades     = check_en && is_mem && !is_load && misaligned;
   assign bad_addr = (adel || ades) ? addr : pc;

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data access unit: alignment exceptions, bus handshake, pipeline stall and load extraction.
// MEMACC_FLUSH_CANCEL_EN lets a flush abandon or drain an in-flight access.
//   state    | meaning
//   IDLE     | no access in flight; accepts an aligned memory op
//   REQ      | data_req high until addr_ok
//   WAIT     | address taken, waiting for data_ok
//   DONE     | rdata_valid_o pulse, no acceptance
//   DRAIN    | flushed access, swallow data_ok (flush-cancel build only)
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OP_W   = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              valid_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [ADDR_W-1:0] bad_addr_o,
   output logic [31:0]       rdata_o,
   output logic              rdata_valid_o,
   mem_access_unit_if.master bus
);

   mau_state_e        state_q;
   logic              req_q, wr_q, is_load_q, signed_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   logic              chk_en, chk_mem, chk_load, chk_signed, chk_adel, chk_ades;
   logic [1:0]        chk_size;
   logic              accept, complete, flush_cancel, drain_stall;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;
   mau_state_e        drain_st;

   assign chk_en = (state_q == ST_IDLE) && valid_i;

   mem_align_chk #(.ADDR_W(ADDR_W), .OP_W(OP_W)) u_align_chk (
      .check_en  (chk_en),
      .op        (op_i),
      .addr      (addr_i),
      .pc        (pc_i),
      .is_mem    (chk_mem),
      .is_load   (chk_load),
      .is_signed (chk_signed),
      .size      (chk_size),
      .adel      (chk_adel),
      .ades      (chk_ades),
      .bad_addr  (bad_addr_o)
   );

`ifdef MEMACC_FLUSH_CANCEL_EN
   assign flush_cancel = flush_i;
   assign drain_st     = ST_DRAIN;
   assign drain_stall  = (state_q == ST_DRAIN) && valid_i;
`else
   assign flush_cancel = 1'b0;
   assign drain_st     = ST_IDLE;
   assign drain_stall  = 1'b0;
`endif

   assign adel_o  = chk_adel;
   assign ades_o  = chk_ades;
   assign accept  = chk_en && chk_mem && !chk_adel && !chk_ades && !flush_i;
   assign stall_o = accept || (state_q == ST_REQ) || (state_q == ST_WAIT) || drain_stall;

   // A flushed access that still sees its data_ok must not report a result.
   assign complete = !flush_cancel && bus.data_data_ok &&
                     (((state_q == ST_REQ) && bus.data_addr_ok) || (state_q == ST_WAIT));

   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = bus.data_rdata[7:0];
         2'd1:    ld_byte = bus.data_rdata[15:8];
         2'd2:    ld_byte = bus.data_rdata[23:16];
         default: ld_byte = bus.data_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
      case (size_q)
         SIZE_BYTE: ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
         SIZE_HALF: ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
         default:   ld_data = bus.data_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         req_q         <= 1'b0;
         wr_q          <= 1'b0;
         size_q        <= SIZE_BYTE;
         addr_q        <= '0;
         wdata_q       <= '0;
         is_load_q     <= 1'b0;
         signed_q      <= 1'b0;
         rdata_o       <= '0;
         rdata_valid_o <= 1'b0;
      end else begin
         rdata_valid_o <= complete;
         if (complete && is_load_q) begin
            rdata_o <= ld_data;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_q   <= ST_REQ;
                  req_q     <= 1'b1;
                  wr_q      <= !chk_load;
                  size_q    <= chk_size;
                  addr_q    <= addr_i;
                  wdata_q   <= replicate_wdata(chk_size, wdata_i);
                  is_load_q <= chk_load;
                  signed_q  <= chk_signed;
               end
            end
            ST_REQ: begin
               if (bus.data_addr_ok) begin
                  req_q <= 1'b0;
                  if (bus.data_data_ok) begin
                     state_q <= flush_cancel ? ST_IDLE : ST_DONE;
                  end else begin
                     state_q <= flush_cancel ? drain_st : ST_WAIT;
                  end
               end else if (flush_cancel) begin
                  req_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (bus.data_data_ok) begin
                  state_q <= flush_cancel ? ST_IDLE : ST_DONE;
               end else if (flush_cancel) begin
                  state_q <= drain_st;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
`ifdef MEMACC_FLUSH_CANCEL_EN
            ST_DRAIN: begin
               if (bus.data_data_ok) begin
                  state_q <= ST_IDLE;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.data_req   = req_q;
   assign bus.data_wr    = wr_q;
   assign bus.data_size  = size_q;
   assign bus.data_addr  = addr_q;
   assign bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a byte-arithmetic reference model.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid_i, flush_i;
   logic [7:0]  op_i;
   logic [31:0] addr_i, wdata_i, pc_i;
   logic        stall_o, adel_o, ades_o, rdata_valid_o;
   logic [31:0] bad_addr_o, rdata_o;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_rd = 32'h0;

   mem_access_unit_if #(.ADDR_W(32)) bus_if ();

   mem_access_unit #(.ADDR_W(32), .OP_W(8)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .valid_i       (valid_i),
      .op_i          (op_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .pc_i          (pc_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .adel_o        (adel_o),
      .ades_o        (ades_o),
      .bad_addr_o    (bad_addr_o),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .bus           (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [7:0] op);
      case (op)
         EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
         EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
         EXE_LW_OP, EXE_SW_OP:             return 4;
         default:                          return 0;
      endcase
   endfunction

   function automatic bit is_ld(input logic [7:0] op);
      return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
             (op == EXE_LHU_OP) || (op == EXE_LW_OP);
   endfunction

   function automatic bit misal(input logic [7:0] op, input logic [31:0] a);
      int n = nbytes(op);
      return (n != 0) && ((a % n) != 0);
   endfunction

   function automatic logic [31:0] size_code(input logic [7:0] op);
      int n = nbytes(op);
      return (n == 1) ? 32'd0 : (n == 2) ? 32'd1 : 32'd2;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] wd);
      int n = nbytes(op);
      if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] rd);
      int          n = nbytes(op);
      logic [31:0] mask, v;
      if (n == 4) return rd;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = (rd >> (8 * (a % 4))) & mask;
      if (((op == EXE_LB_OP) || (op == EXE_LH_OP)) && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic chk_idle_bus(input string tag);
      chk({tag, "_req"},   bus_if.data_req, 0);
      chk({tag, "_wr"},    bus_if.data_wr, 0);
      chk({tag, "_size"},  bus_if.data_size, 0);
      chk({tag, "_addr"},  bus_if.data_addr, 0);
      chk({tag, "_wdata"}, bus_if.data_wdata, 0);
      chk({tag, "_rdata"}, rdata_o, 0);
      chk({tag, "_rval"},  rdata_valid_o, 0);
      chk({tag, "_stall"}, stall_o, 0);
   endtask

   // One accepted access; addr_ok after a_dly REQ cycles, data_ok d_dly cycles after addr_ok.
   task automatic do_access(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] pc, input int a_dly, input int d_dly,
                            input logic [31:0] rd);
      int stalls;
      @(negedge clk);
      valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; pc_i = pc; flush_i = 1'b0;
      bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = $urandom;
      #1;
      chk("acc_stall", stall_o, 1);
      chk("acc_exc", {adel_o, ades_o}, 0);
      stalls = 1;
      for (int k = 0; k <= a_dly + d_dly; k++) begin
         @(negedge clk);
         bus_if.data_addr_ok = (k == a_dly);
         bus_if.data_data_ok = (k == a_dly + d_dly);
         bus_if.data_rdata   = bus_if.data_data_ok ? rd : $urandom;
         #1;
         if (k <= a_dly) begin
            chk("req_hi",    bus_if.data_req, 1);
            chk("req_addr",  bus_if.data_addr, a);
            chk("req_wr",    bus_if.data_wr, !is_ld(op));
            chk("req_size",  bus_if.data_size, size_code(op));
            if (!is_ld(op)) chk("req_wdata", bus_if.data_wdata, model_wdata(op, wd));
         end else begin
            chk("wait_req_lo", bus_if.data_req, 0);
         end
         chk("busy_exc", {adel_o, ades_o}, 0);
         if (stall_o) stalls++;
      end
      @(negedge clk);
      bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = $urandom;
      valid_i = 1'b0;
      if (is_ld(op)) exp_rd = model_load(op, a, rd);
      #1;
      chk("done_rval",  rdata_valid_o, 1);
      chk("done_stall", stall_o, 0);
      chk("done_rdata", rdata_o, exp_rd);
      chk("stall_cnt",  stalls, a_dly + d_dly + 2);
      @(negedge clk);
      #1;
      chk("rval_pulse", rdata_valid_o, 0);
   endtask

   // A non-accepting cycle: exception, non-memory op or flushed acceptance.
   task automatic chk_exc(input logic [7:0] op, input logic [31:0] a, input logic [31:0] pc,
                          input logic fl);
      bit mis, exc;
      @(negedge clk);
      valid_i = 1'b1; op_i = op; addr_i = a; pc_i = pc; flush_i = fl; wdata_i = $urandom;
      mis = misal(op, a);
      exc = mis && (nbytes(op) != 0);
      #1;
      chk("adel",  adel_o, exc && is_ld(op));
      chk("ades",  ades_o, exc && !is_ld(op));
      chk("bad",   bad_addr_o, exc ? a : pc);
      chk("stall", stall_o, (nbytes(op) != 0) && !mis && !fl);
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0;
      #1;
      chk("no_req", bus_if.data_req, 0);
   endtask

   initial begin
      logic [7:0]  ops [10];
      logic [7:0]  op;
      logic [31:0] a;
      ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
              EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP, EXE_NOP_OP};

      resetn = 1'b0; valid_i = 1'b0; flush_i = 1'b0; op_i = '0;
      addr_i = '0; wdata_i = '0; pc_i = '0;
      bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_idle_bus("rst");
      resetn = 1'b1;

      do_access(EXE_LW_OP, 32'h1000_0004, 32'h0, 32'hBFC0_0000, 0, 0, 32'hDEAD_BEEF);
      chk_exc(EXE_LH_OP, 32'h0000_0003, 32'hBFC0_0100, 1'b0);
      chk_exc(EXE_SW_OP, 32'h0000_0002, 32'hBFC0_0104, 1'b0);
      chk_exc(EXE_ADD_OP, 32'h0000_0003, 32'hBFC0_0108, 1'b0);
      do_access(EXE_LB_OP,  32'h0000_0012, 32'h0, 32'hBFC0_010C, 0, 0, 32'h0080_0000);
      do_access(EXE_LBU_OP, 32'h0000_0012, 32'h0, 32'hBFC0_0110, 0, 0, 32'h0080_0000);
      do_access(EXE_SB_OP,  32'h0000_0021, 32'h1234_56AB, 32'hBFC0_0114, 3, 0, 32'h0);
      do_access(EXE_LH_OP,  32'h0000_0032, 32'h0, 32'hBFC0_0118, 1, 2, 32'h8001_7FFF);
      chk_exc(EXE_LW_OP, 32'h0000_0040, 32'hBFC0_011C, 1'b1);

      // Flush while waiting for data_ok.
      @(negedge clk);
      valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h2000_0008; pc_i = 32'hBFC0_0120;
      @(negedge clk);
      bus_if.data_addr_ok = 1'b1;
      @(negedge clk);
      bus_if.data_addr_ok = 1'b0; flush_i = 1'b1;
      #1;
      chk("fw_stall_wait", stall_o, 1);
      @(negedge clk);
      flush_i = 1'b0; bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'h5A5A_1234;
      #1;
      chk("fw_stall_late", stall_o, 1);
      @(negedge clk);
      bus_if.data_data_ok = 1'b0; valid_i = 1'b0;
`ifdef MEMACC_FLUSH_CANCEL_EN
      #1;
      chk("fw_drain_rval", rdata_valid_o, 0);
      chk("fw_drain_rdata", rdata_o, exp_rd);
`else
      exp_rd = 32'h5A5A_1234;
      #1;
      chk("fw_done_rval", rdata_valid_o, 1);
      chk("fw_done_rdata", rdata_o, exp_rd);
`endif
      @(negedge clk);
      #1;
      chk("fw_idle_rval", rdata_valid_o, 0);

      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 9)];
         a  = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         if ((nbytes(op) == 0) || misal(op, a)) begin
            chk_exc(op, a, $urandom, 1'b0);
         end else begin
            do_access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom);
         end
      end

      // Reset in WAIT after a store has loaded every bus field with non-zero values.
      @(negedge clk);
      valid_i = 1'b1; op_i = EXE_SW_OP; addr_i = 32'h3000_0010; wdata_i = 32'hCAFE_F00D;
      @(negedge clk);
      bus_if.data_addr_ok = 1'b1;
      @(negedge clk);
      bus_if.data_addr_ok = 1'b0;
      #1;
      chk("rw_wait_wr", bus_if.data_wr, 1);
      resetn = 1'b0; valid_i = 1'b0;
      #1;
      chk_idle_bus("rw");
      @(negedge clk);
      resetn = 1'b1;
      exp_rd = 32'h0;
      do_access(EXE_LHU_OP, 32'h0000_0052, 32'h0, 32'hBFC0_0200, 0, 1, 32'h9876_5432);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit for the MIPS pipeline. It checks load/store alignment and raises AdEL/AdES with the faulting address. For aligned accesses it drives the SRAM-like data bus handshake, stalls the pipeline until the response arrives, and returns byte-, half- or word-extracted load data. It sits between the M-stage pipeline register and the data bus bridge, and replaces the purely combinational exception checker.

## Interface
- ADDR_W, 32, address width of `addr_i`, `pc_i`, `bad_addr_o` and `data_addr`; must be at least 2.
- OP_W, 8, width of the ALU-control op code carrying EXE_*_OP values.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid_i  in  1  M-stage instruction valid.
- op_i  in  OP_W  ALU-control op; LB/LBU/LH/LHU/LW/SB/SH/SW are memory ops, all others are ignored.
- addr_i  in  ADDR_W  effective address.
- wdata_i  in  32  store data, unaligned, in the low bits.
- pc_i  in  ADDR_W  PC of the M-stage instruction.
- flush_i  in  1  pipeline flush (exception or eret).
- stall_o  out  1  holds the M stage and everything upstream.
- adel_o, ades_o  out  1  load / store address error.
- bad_addr_o  out  ADDR_W  equals `addr_i` when adel_o or ades_o is high, otherwise equals `pc_i`.
- rdata_o  out  32  extended load result, registered.
- rdata_valid_o  out  1  one-cycle pulse when the access completes.
- data_req, data_wr  out  1  bus request; write when high.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W; data_wdata  out  32.
- data_addr_ok, data_data_ok  in  1; data_rdata  in  32.

## Operation
- States: IDLE, REQ, WAIT, DONE; DRAIN exists only when the macro is defined.
- Alignment rules, evaluated only when state = IDLE and valid_i = 1:
  - LB, LBU, SB: always aligned.
  - LH, LHU, SH: misaligned when addr_i[0] = 1.
  - LW, SW: misaligned when addr_i[1:0] != 0.
- A misaligned load raises adel_o; a misaligned store raises ades_o. Both are combinational, no request is issued, and stall_o stays 0.
- In any state other than IDLE, adel_o and ades_o are 0.
- IDLE with valid_i = 1, an aligned memory op and flush_i = 0:
  - Latch op, address, size and replicated wdata (SB: byte ×4; SH: half ×2; SW: unchanged).
  - stall_o = 1; go to REQ.
- REQ: data_req = 1 with the latched fields.
  - addr_ok and data_ok both high → DONE.
  - addr_ok only → WAIT.
- WAIT: data_req = 0. On data_ok → DONE.
- Leaving REQ or WAIT on data_ok: capture the extracted load into rdata_o.
  - LB/LBU: lane selected by addr[1:0], sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: full word.
  - Stores leave rdata_o unchanged.
- DONE: rdata_valid_o = 1, stall_o = 0, no new acceptance; next state is IDLE.
- stall_o = 1 whenever state is REQ or WAIT, and in IDLE during the accept cycle.
- data_rdata is ignored except on data_ok in REQ or WAIT.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; rdata_o = 0, rdata_valid_o = 0.
  - data_req, data_wr, data_size, data_addr and data_wdata all = 0.
  - Any in-flight bus transaction is abandoned.
- Minimum load latency: accept in cycle 0, addr_ok and data_ok in cycle 1, rdata_valid_o in cycle 2. stall_o is high in cycles 0–1.
- Each extra cycle without addr_ok or data_ok adds one stall cycle.
- data_req stays high in REQ until addr_ok is seen. The latched request fields are held constant throughout.
- Inputs are assumed stable while stall_o = 1; they are sampled only on the accept cycle.

## Configuration
- MEMACC_FLUSH_CANCEL_EN defined:
  - flush_i in REQ without addr_ok → IDLE, data_req drops the next cycle.
  - flush_i in REQ with addr_ok, or in WAIT → DRAIN.
  - DRAIN waits for data_ok, then goes to IDLE without capturing data or pulsing rdata_valid_o.
  - stall_o = valid_i in DRAIN.
- MEMACC_FLUSH_CANCEL_EN undefined:
  - flush_i only blocks acceptance in IDLE.
  - An accepted access always completes and pulses rdata_valid_o; the pipeline discards the result.

## Structure
- The shared defines header holds:
  - EXE_*_OP codes;
  - state localparams;
  - data_size codes.
- Sub-module mem_align_chk: a combinational op/address → adel, ades, bad_addr, size decoder, instantiated once.

## Test plan
- LW at 0x1000_0004, with addr_ok and data_ok in the cycle after accept, data_rdata = 0xDEAD_BEEF → rdata_o = 0xDEADBEEF at cycle 2, stall_o high for exactly 2 cycles.
- LH at 0x0000_0003, pc 0xBFC0_0100 → adel_o = 1, bad_addr_o = 0x00000003, data_req never rises, stall_o = 0.
- SW at 0x0000_0002 → ades_o = 1, bad_addr_o = 0x00000002. Non-memory op with a misaligned address → no exception, bad_addr_o = pc.
- LB at addr[1:0] = 2 with data_rdata = 0x0080_0000 → rdata_o = 0xFFFFFF80; the same access as LBU → 0x00000080.
- SB wdata 0x1234_56AB, addr_ok delayed by 3 cycles → data_wdata = 0xABABABAB and data_size = 0 held constant, data_wr = 1, 5 stall cycles in total.
- Flush in WAIT with the macro defined → DRAIN, no rdata_valid_o. Reset asserted in WAIT → all outputs 0 immediately.
